res_station_array: RTL and testbench

- Parametrised reservation-station array for the Tomasulo core. It supersedes the single-entry res_word station.
- Holds DEPTH in-flight instructions and snoops NUM_CDB common-data-bus channels for outstanding operand tags.
- Issues the lowest-indexed ready entry to its functional unit through a valid/ready handshake.
- Sits between the instruction queue / dispatch logic and an ALU, branch or address unit.

---
 rtl/res_station_array.sv | 195 +++++++++++++++++++
 tb/tb_res_station_array.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_station_array.sv
// Multi-entry reservation station: holds dispatched instructions, snoops the CDB
// for missing operands and issues the lowest-indexed ready entry to its FU.
module res_station_array #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_CDB = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  output logic                        alloc_ready,
  input  logic [3:0]                  alloc_op,
  input  logic [2:0]                  alloc_funct3,
  input  logic                        alloc_funct7,
  input  logic [TAG_W-1:0]            alloc_src1_tag,
  input  logic [TAG_W-1:0]            alloc_src2_tag,
  input  logic [DATA_W-1:0]           alloc_src1_data,
  input  logic [DATA_W-1:0]           alloc_src2_data,
  input  logic                        alloc_src1_valid,
  input  logic                        alloc_src2_valid,
  input  logic [TAG_W-1:0]            alloc_rd_tag,
  input  logic [DATA_W-1:0]           alloc_imm,
  input  logic [DATA_W-1:0]           alloc_pc,
  input  logic [NUM_CDB-1:0]          cdb_request,
  input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
  output logic                        issue_valid,
  input  logic                        issue_ready,
  output logic [3:0]                  issue_op,
  output logic [2:0]                  issue_funct3,
  output logic                        issue_funct7,
  output logic [DATA_W-1:0]           issue_src1_data,
  output logic [DATA_W-1:0]           issue_src2_data,
  output logic [DATA_W-1:0]           issue_imm,
  output logic [DATA_W-1:0]           issue_pc,
  output logic [TAG_W-1:0]            issue_tag,
  output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [3:0]        op;
    logic [2:0]        funct3;
    logic              funct7;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_data;
    logic              s2_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } entry_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  entry_t             new_ent;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [DEPTH-1:0]   rdy;
  logic [DEPTH-1:0]   free;
  logic [IDX_W-1:0]   issue_sel, free_sel;
  logic               alloc_fire, issue_fire;
  logic [DATA_W:0]    hit1, hit2;

  // Lowest channel index wins when several channels carry the same tag.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        req,
    input logic [NUM_CDB*TAG_W-1:0]  tags,
    input logic [NUM_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] hit;
    hit = '0;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (req[c] && (tags[c*TAG_W +: TAG_W] == tag)) hit = {1'b1, data[c*DATA_W +: DATA_W]};
    end
    return hit;
  endfunction

  always_comb begin
    rdy       = '0;
    free      = '0;
    issue_sel = '0;
    free_sel  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i]  = ent_q[i].valid & ent_q[i].s1_valid & ent_q[i].s2_valid;
      free[i] = ~ent_q[i].valid;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i])  issue_sel = IDX_W'(i);
      if (free[i]) free_sel  = IDX_W'(i);
    end
  end

  assign alloc_ready = (occ_q < OCC_W'(DEPTH));
  assign issue_valid = |rdy;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign issue_fire  = issue_valid & issue_ready;
  assign occupancy   = occ_q;

  // Payload is zero whenever nothing is ready so the FU never sees stale data.
  always_comb begin
    issue_op        = '0;
    issue_funct3    = '0;
    issue_funct7    = 1'b0;
    issue_src1_data = '0;
    issue_src2_data = '0;
    issue_imm       = '0;
    issue_pc        = '0;
    issue_tag       = '0;
    if (issue_valid) begin
      issue_op        = ent_q[issue_sel].op;
      issue_funct3    = ent_q[issue_sel].funct3;
      issue_funct7    = ent_q[issue_sel].funct7;
      issue_src1_data = ent_q[issue_sel].s1_data;
      issue_src2_data = ent_q[issue_sel].s2_data;
      issue_imm       = ent_q[issue_sel].imm;
      issue_pc        = ent_q[issue_sel].pc;
      issue_tag       = ent_q[issue_sel].rd_tag;
    end
  end

  // Incoming entry, with operands captured from a same-cycle broadcast.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.op       = alloc_op;
    new_ent.funct3   = alloc_funct3;
    new_ent.funct7   = alloc_funct7;
    new_ent.s1_tag   = alloc_src1_tag;
    new_ent.s1_data  = alloc_src1_data;
    new_ent.s1_valid = alloc_src1_valid;
    new_ent.s2_tag   = alloc_src2_tag;
    new_ent.s2_data  = alloc_src2_data;
    new_ent.s2_valid = alloc_src2_valid;
    new_ent.rd_tag   = alloc_rd_tag;
    new_ent.imm      = alloc_imm;
    new_ent.pc       = alloc_pc;
    hit1 = cdb_lookup(alloc_src1_tag, cdb_request, cdb_tag, cdb_data);
    hit2 = cdb_lookup(alloc_src2_tag, cdb_request, cdb_tag, cdb_data);
    if (!alloc_src1_valid && hit1[DATA_W]) begin
      new_ent.s1_valid = 1'b1;
      new_ent.s1_data  = hit1[DATA_W-1:0];
    end
    if (!alloc_src2_valid && hit2[DATA_W]) begin
      new_ent.s2_valid = 1'b1;
      new_ent.s2_data  = hit2[DATA_W-1:0];
    end
  end

  // Next state: snoop, then issue, then alloc, with flush overriding all.
  always_comb begin
    logic [DATA_W:0] h1, h2;
    ent_d = ent_q;
    for (int i = 0; i < DEPTH; i++) begin
      h1 = cdb_lookup(ent_q[i].s1_tag, cdb_request, cdb_tag, cdb_data);
      h2 = cdb_lookup(ent_q[i].s2_tag, cdb_request, cdb_tag, cdb_data);
      if (ent_q[i].valid && !ent_q[i].s1_valid && h1[DATA_W]) begin
        ent_d[i].s1_valid = 1'b1;
        ent_d[i].s1_data  = h1[DATA_W-1:0];
      end
      if (ent_q[i].valid && !ent_q[i].s2_valid && h2[DATA_W]) begin
        ent_d[i].s2_valid = 1'b1;
        ent_d[i].s2_data  = h2[DATA_W-1:0];
      end
    end
    if (issue_fire) ent_d[issue_sel].valid = 1'b0;
    if (alloc_fire) ent_d[free_sel] = new_ent;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
    end

    occ_d = occ_q;
    if (flush)                          occ_d = '0;
    else if (alloc_fire && !issue_fire) occ_d = occ_q + OCC_W'(1);
    else if (!alloc_fire && issue_fire) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_res_station_array.sv
// Bench for res_station_array: vector table for basic alloc/issue ordering,
// directed sequences for CDB, bypass, full, flush and async reset.
module tb_res_station_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_op;
  logic [2:0]  alloc_funct3;
  logic        alloc_funct7;
  logic [2:0]  alloc_src1_tag, alloc_src2_tag, alloc_rd_tag;
  logic [31:0] alloc_src1_data, alloc_src2_data, alloc_imm, alloc_pc;
  logic        alloc_src1_valid, alloc_src2_valid;
  logic [1:0]  cdb_request;
  logic [5:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        issue_valid, issue_ready;
  logic [3:0]  issue_op;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [31:0] issue_src1_data, issue_src2_data, issue_imm, issue_pc;
  logic [2:0]  issue_tag;
  logic [2:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  res_station_array #(.DEPTH(4), .TAG_W(3), .DATA_W(32), .NUM_CDB(2)) dut (
    .clk(clk), .rst(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_funct3(alloc_funct3), .alloc_funct7(alloc_funct7),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_data(alloc_src1_data), .alloc_src2_data(alloc_src2_data),
    .alloc_src1_valid(alloc_src1_valid), .alloc_src2_valid(alloc_src2_valid),
    .alloc_rd_tag(alloc_rd_tag), .alloc_imm(alloc_imm), .alloc_pc(alloc_pc),
    .cdb_request(cdb_request), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_src1_data(issue_src1_data), .issue_src2_data(issue_src2_data),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_tag(issue_tag),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [2:0]  tag;
    logic [3:0]  op;
    logic [31:0] s1, s2;
  } exp_t;

  typedef struct {
    logic        av;
    logic [31:0] d1, d2;
    logic [2:0]  rd;
    logic        ir;
    logic        e_iv;
    logic [2:0]  e_occ;
    logic        e_ar;
    logic [2:0]  e_tag;
    logic [31:0] e_s1, e_s2;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[8];

  function automatic vec_t row(logic av, logic [31:0] d1, logic [31:0] d2, logic [2:0] rd,
                               logic ir, logic e_iv, logic [2:0] e_occ, logic e_ar,
                               logic [2:0] e_tag, logic [31:0] e_s1, logic [31:0] e_s2);
    vec_t v;
    v.av = av; v.d1 = d1; v.d2 = d2; v.rd = rd; v.ir = ir;
    v.e_iv = e_iv; v.e_occ = e_occ; v.e_ar = e_ar; v.e_tag = e_tag; v.e_s1 = e_s1; v.e_s2 = e_s2;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Per-rd derived fields let the scoreboard verify imm/pc/funct routing too.
  task automatic drive_alloc(input logic [3:0] op, input logic [2:0] t1, input logic v1,
                             input logic [31:0] d1, input logic [2:0] t2, input logic v2,
                             input logic [31:0] d2, input logic [2:0] rd);
    alloc_valid = 1'b1; alloc_op = op; alloc_rd_tag = rd;
    alloc_funct3 = rd; alloc_funct7 = rd[0];
    alloc_src1_tag = t1; alloc_src1_valid = v1; alloc_src1_data = d1;
    alloc_src2_tag = t2; alloc_src2_valid = v2; alloc_src2_data = d2;
    alloc_imm = 32'(rd) << 8;
    alloc_pc  = 32'h1000 + (32'(rd) << 2);
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [2:0] rd,
                          input logic [31:0] s1, input logic [31:0] s2);
    exp_t e;
    e.tag = rd; e.op = op; e.s1 = s1; e.s2 = s2;
    sbq.push_back(e);
  endtask

  task automatic drive_cdb(input logic [1:0] req, input logic [2:0] t0, input logic [31:0] d0,
                           input logic [2:0] t1, input logic [31:0] d1);
    cdb_request = req;
    cdb_tag     = {t1, t0};
    cdb_data    = {d1, d0};
  endtask

  task automatic idle();
    alloc_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0; cdb_request = 2'b00;
  endtask

  // Compare a handshake's payload against the queued expectation for its tag.
  task automatic sb_check();
    int idx;
    idx = -1;
    if (!flush && issue_valid && issue_ready) begin
      for (int i = 0; i < sbq.size(); i++) if (idx < 0 && sbq[i].tag == issue_tag) idx = i;
      n_tests++;
      if (idx < 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: issued tag %0d expected none", issue_tag);
      end else if (issue_src1_data !== sbq[idx].s1 || issue_src2_data !== sbq[idx].s2 ||
                   issue_op !== sbq[idx].op || issue_funct3 !== sbq[idx].tag ||
                   issue_funct7 !== sbq[idx].tag[0] ||
                   issue_imm !== (32'(sbq[idx].tag) << 8) ||
                   issue_pc !== (32'h1000 + (32'(sbq[idx].tag) << 2))) begin
        n_fail++;
        $display("FAIL sb_payload tag %0d: got s1=0x%0h s2=0x%0h op=%0d imm=0x%0h pc=0x%0h expected s1=0x%0h s2=0x%0h op=%0d",
                 issue_tag, issue_src1_data, issue_src2_data, issue_op, issue_imm, issue_pc,
                 sbq[idx].s1, sbq[idx].s2, sbq[idx].op);
        sbq.delete(idx);
      end else begin
        sbq.delete(idx);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    drive_alloc(4'd0, 3'd0, 1'b0, 32'd0, 3'd0, 1'b0, 32'd0, 3'd0);
    alloc_valid = 1'b0;
    drive_cdb(2'b00, 3'd0, 32'd0, 3'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_issue_valid", 32'(issue_valid), 32'd0);
    check("reset_occupancy",   32'(occupancy),   32'd0);
    check("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    check("reset_payload",     issue_src1_data,  32'd0);

    // av d1 d2 rd ir | iv occ ar tag s1 s2 (state after the edge)
    tbl[0] = row(1, 32'd5,    32'd7,    3'd2, 0, 1, 3'd1, 1, 3'd2, 32'd5,    32'd7);
    tbl[1] = row(0, 32'd0,    32'd0,    3'd0, 1, 0, 3'd0, 1, 3'd0, 32'd0,    32'd0);
    tbl[2] = row(1, 32'h10,   32'h20,   3'd5, 1, 1, 3'd1, 1, 3'd5, 32'h10,   32'h20);
    tbl[3] = row(1, 32'h30,   32'h40,   3'd6, 0, 1, 3'd2, 1, 3'd5, 32'h10,   32'h20);
    tbl[4] = row(1, 32'h1,    32'h2,    3'd7, 1, 1, 3'd2, 1, 3'd6, 32'h30,   32'h40);
    tbl[5] = row(1, 32'h3,    32'h4,    3'd1, 1, 1, 3'd2, 1, 3'd1, 32'h3,    32'h4);
    tbl[6] = row(0, 32'd0,    32'd0,    3'd0, 1, 1, 3'd1, 1, 3'd7, 32'h1,    32'h2);
    tbl[7] = row(0, 32'd0,    32'd0,    3'd0, 1, 0, 3'd0, 1, 3'd0, 32'd0,    32'd0);
    for (int r = 0; r < 8; r++) begin
      idle();
      if (tbl[r].av) begin
        drive_alloc(4'd1, 3'd0, 1'b1, tbl[r].d1, 3'd0, 1'b1, tbl[r].d2, tbl[r].rd);
        push_exp(4'd1, tbl[r].rd, tbl[r].d1, tbl[r].d2);
      end
      issue_ready = tbl[r].ir;
      tick();
      check($sformatf("tbl%0d_issue_valid", r), 32'(issue_valid), 32'(tbl[r].e_iv));
      check($sformatf("tbl%0d_occupancy", r),   32'(occupancy),   32'(tbl[r].e_occ));
      check($sformatf("tbl%0d_alloc_ready", r), 32'(alloc_ready), 32'(tbl[r].e_ar));
      check($sformatf("tbl%0d_issue_tag", r),   32'(issue_tag),   32'(tbl[r].e_tag));
      check($sformatf("tbl%0d_src1", r),        issue_src1_data,  tbl[r].e_s1);
      check($sformatf("tbl%0d_src2", r),        issue_src2_data,  tbl[r].e_s2);
    end
    idle();

    // Operand resolved by a later broadcast; no same-cycle forwarding to issue.
    drive_alloc(4'd2, 3'd3, 1'b0, 32'd0, 3'd0, 1'b1, 32'd9, 3'd1);
    push_exp(4'd2, 3'd1, 32'hDEAD, 32'd9);
    tick();
    idle();
    check("cdb_wait_issue_valid", 32'(issue_valid), 32'd0);
    check("cdb_wait_occupancy",   32'(occupancy),   32'd1);
    tick();
    check("cdb_wait2_issue_valid", 32'(issue_valid), 32'd0);
    drive_cdb(2'b01, 3'd3, 32'hDEAD, 3'd0, 32'd0);
    #1;
    check("cdb_no_forward", 32'(issue_valid), 32'd0);
    tick();
    idle();
    check("cdb_issue_valid", 32'(issue_valid), 32'd1);
    check("cdb_src1",        issue_src1_data,  32'hDEAD);
    check("cdb_tag",         32'(issue_tag),   32'd1);
    issue_ready = 1'b1;
    tick();
    idle();
    check("cdb_drain_occ", 32'(occupancy), 32'd0);

    // Allocation bypass from a same-cycle broadcast on channel 1.
    drive_alloc(4'd3, 3'd4, 1'b0, 32'd0, 3'd0, 1'b1, 32'h22, 3'd4);
    drive_cdb(2'b10, 3'd0, 32'd0, 3'd4, 32'hBEEF);
    push_exp(4'd3, 3'd4, 32'hBEEF, 32'h22);
    tick();
    idle();
    check("bypass_issue_valid", 32'(issue_valid), 32'd1);
    check("bypass_src1",        issue_src1_data,  32'hBEEF);
    issue_ready = 1'b1;
    tick();
    idle();
    check("bypass_drain_occ", 32'(occupancy), 32'd0);

    // Two channels resolve both operands in one cycle.
    drive_alloc(4'd4, 3'd1, 1'b0, 32'd0, 3'd5, 1'b0, 32'd0, 3'd3);
    push_exp(4'd4, 3'd3, 32'h11, 32'h55);
    tick();
    idle();
    check("dual_wait_issue_valid", 32'(issue_valid), 32'd0);
    drive_cdb(2'b11, 3'd1, 32'h11, 3'd5, 32'h55);
    tick();
    idle();
    check("dual_issue_valid", 32'(issue_valid), 32'd1);
    check("dual_src1",        issue_src1_data,  32'h11);
    check("dual_src2",        issue_src2_data,  32'h55);
    issue_ready = 1'b1;
    tick();
    idle();

    // Same tag on both channels: channel 0 must win.
    drive_alloc(4'd5, 3'd6, 1'b0, 32'd0, 3'd0, 1'b1, 32'h77, 3'd6);
    push_exp(4'd5, 3'd6, 32'hA0, 32'h77);
    tick();
    idle();
    drive_cdb(2'b11, 3'd6, 32'hA0, 3'd6, 32'hB1);
    tick();
    idle();
    check("prio_src1", issue_src1_data, 32'hA0);
    issue_ready = 1'b1;
    tick();
    idle();
    check("prio_drain_occ", 32'(occupancy), 32'd0);

    // Fill with unresolved entries waiting on tags 4..7.
    for (int i = 0; i < 4; i++) begin
      drive_alloc(4'd6, 3'(i + 4), 1'b0, 32'd0, 3'd0, 1'b1, 32'h200 + 32'(i), 3'(i));
      push_exp(4'd6, 3'(i), (i == 0) ? 32'h44 : 32'h66, 32'h200 + 32'(i));
      tick();
    end
    idle();
    check("full_alloc_ready", 32'(alloc_ready), 32'd0);
    check("full_occupancy",   32'(occupancy),   32'd4);
    check("full_issue_valid", 32'(issue_valid), 32'd0);
    drive_alloc(4'd1, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd7);
    tick();
    idle();
    check("full_ignored_occ", 32'(occupancy), 32'd4);
    drive_cdb(2'b01, 3'd6, 32'h66, 3'd0, 32'd0);
    tick();
    idle();
    check("full_e2_issue_valid", 32'(issue_valid), 32'd1);
    check("full_e2_tag",         32'(issue_tag),   32'd2);
    issue_ready = 1'b1;
    drive_alloc(4'd1, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd7);
    tick();
    idle();
    check("after_full_occ",         32'(occupancy),   32'd3);
    check("after_full_alloc_ready", 32'(alloc_ready), 32'd1);

    // Flush overrides a simultaneous alloc and issue handshake.
    drive_cdb(2'b01, 3'd4, 32'h44, 3'd0, 32'd0);
    tick();
    idle();
    check("preflush_issue_valid", 32'(issue_valid), 32'd1);
    check("preflush_tag",         32'(issue_tag),   32'd0);
    flush = 1'b1;
    issue_ready = 1'b1;
    drive_alloc(4'd1, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd5);
    tick();
    idle();
    sbq.delete();
    check("flush_occupancy",   32'(occupancy),   32'd0);
    check("flush_issue_valid", 32'(issue_valid), 32'd0);
    check("flush_alloc_ready", 32'(alloc_ready), 32'd1);

    // Asynchronous reset mid-cycle.
    drive_alloc(4'd1, 3'd0, 1'b1, 32'd1, 3'd0, 1'b1, 32'd2, 3'd2);
    tick();
    idle();
    check("prerst_issue_valid", 32'(issue_valid), 32'd1);
    check("prerst_occupancy",   32'(occupancy),   32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_issue_valid", 32'(issue_valid), 32'd0);
    check("async_rst_occupancy",   32'(occupancy),   32'd0);
    check("async_rst_alloc_ready", 32'(alloc_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_issue_valid", 32'(issue_valid), 32'd0);

    check("sb_leftover", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
